// File: rtl/mux_pkg.sv
// Shared types and helpers for the N-input stream multiplexer/arbiter.
// Imported by the top level and its round-robin picker.
package mux_pkg;

   typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mux_mode_t;

   // Channel words of up to MAX_CH_W bits packed into a bus of up to MAX_BUS_W bits.
   localparam int unsigned MAX_BUS_W = 1024;
   localparam int unsigned MAX_CH_W  = 64;

   // Returns channel idx of a packed bus; the caller truncates to its own width.
   function automatic logic [MAX_CH_W-1:0] ch_word(input logic [MAX_BUS_W-1:0] packed_bus,
                                                  input int unsigned idx,
                                                  input int unsigned width);
      logic [MAX_BUS_W-1:0] shifted;
      shifted = packed_bus >> (idx * width);
      return shifted[MAX_CH_W-1:0];
   endfunction

endpackage

// File: rtl/mux_arb_n_if.sv
// Stream bundle between the producers, the mux and the shared consumer.
// slave is the mux's view; master is the producer/consumer side.
interface mux_arb_n_if #(
   parameter int WIDTH = 4,
   parameter int N     = 4,
   parameter int SELW  = $clog2(N)
);
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_ready;
   logic [WIDTH-1:0]   out_data;
   logic               out_valid;
   logic               out_ready;
   logic [SELW-1:0]    out_ch;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_ch
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_ch
   );
endinterface

// File: rtl/mux_arb_n_rr_pick.sv
// Wrap-around priority search: first requesting channel at or after ptr,
// wrapping modulo N so non-power-of-two channel counts behave correctly.
module rr_pick #(
   parameter int N    = 4,
   parameter int SELW = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   output logic [SELW-1:0] gnt,
   output logic            gnt_valid
);
   logic [2*N-1:0] req_dbl;
   logic [N-1:0]   rot;

   // Doubling the vector makes the shift a rotation modulo N rather than 2^SELW.
   assign req_dbl = {req, req} >> ptr;
   assign rot     = req_dbl[N-1:0];

   always_comb begin
      gnt       = '0;
      gnt_valid = 1'b0;
      // Descending scan: the lowest offset from ptr is written last and wins.
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k[SELW-1:0]]) begin
            gnt       = SELW'((int'(ptr) + k) % N);
            gnt_valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/mux_arb_n.sv
// N-input valid/ready stream mux with fixed-select or round-robin grant
// feeding a single output register (one cycle latency, full throughput).
module mux_arb_n
   import mux_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int N     = 4,
   parameter int SELW  = $clog2(N)
) (
   input  logic            clk,
   input  logic            reset,
   input  mux_mode_t       mode,
   input  logic [SELW-1:0] s,
   mux_arb_n_if.slave      bus
);
   logic [SELW-1:0]  ptr;
   logic [SELW-1:0]  rr_gnt;
   logic             rr_valid;
   logic             fixed_valid;
   logic [SELW-1:0]  gnt;
   logic             gnt_valid;
   logic             ld;
   logic             take;
   logic [WIDTH-1:0] gnt_data;

   rr_pick #(.N(N), .SELW(SELW)) u_rr_pick (
      .req       (bus.in_valid),
      .ptr       (ptr),
      .gnt       (rr_gnt),
      .gnt_valid (rr_valid)
   );

   // A select beyond the last channel never grants.
   assign fixed_valid = (32'(s) < N) && bus.in_valid[s];

   assign gnt       = (mode == MODE_RR) ? rr_gnt   : s;
   assign gnt_valid = (mode == MODE_RR) ? rr_valid : fixed_valid;

   // Register may load when empty or when its word leaves this same cycle.
   assign ld       = !bus.out_valid || bus.out_ready;
   assign take     = ld && gnt_valid && !reset;
   assign gnt_data = WIDTH'(ch_word(MAX_BUS_W'(bus.in_data), 32'(gnt), 32'(WIDTH)));

   always_comb begin
      // NOTE: default first so every path assigns in_ready and no latch is inferred.
      bus.in_ready = '0;
      if (take) bus.in_ready[gnt] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments and a reset sampled on the clock edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_ch    <= '0;
         ptr           <= '0;
      end else if (take) begin
         bus.out_valid <= 1'b1;
         bus.out_data  <= gnt_data;
         bus.out_ch    <= gnt;
         if (mode == MODE_RR) ptr <= (32'(gnt) == N - 1) ? '0 : SELW'(32'(gnt) + 1);
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end
endmodule

// File: doc/mux_arb_n.md
Name: mux_arb_n

Overview:
- Parametrised N-input, WIDTH-bit stream multiplexer with valid/ready handshakes on every input and on the output.
- Two modes: fixed select (driven by `s`) or round-robin arbitration across all inputs.
- The selected word is captured in a single output register, so the block gives one cycle of latency and is pipeline-safe.
- Sits between several producer blocks and one shared consumer.

Parameters:
- WIDTH, 4, data width of each channel in bits.
- N, 4, number of input channels (N >= 2; need not be a power of two).
- SELW, $clog2(N), width of the select and channel-ID fields. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = MODE_FIXED, 1 = MODE_RR.
- s  input  SELW  channel select, used in MODE_FIXED only.
- in_data  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; combinational; at most one bit is high.
- out_data  output  WIDTH  registered data.
- out_valid  output  1  registered valid.
- out_ready  input  1  consumer ready.
- out_ch  output  SELW  registered index of the channel that supplied out_data.

Behaviour:
- Reset, sampled at the clk edge:
  - out_valid=0, out_data=0, out_ch=0.
  - RR pointer ptr=0.
  - in_ready=0 while reset is high.
- Reset asserted mid-transfer discards the held word. No handshake completes on a cycle where reset=1.
- Output register has two states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- Load enable: ld = !out_valid | out_ready. This allows back-to-back transfers at one word per cycle.
- Grant:
  - MODE_FIXED:
    - gnt_valid = (s < N) & in_valid[s]; gnt = s.
    - s >= N never grants.
  - MODE_RR:
    - Search channels ptr, ptr+1, …, N-1, 0, …, ptr-1, wrapping modulo N (not modulo 2^SELW).
    - gnt is the first channel with valid=1; gnt_valid = |in_valid.
- in_ready[i] = ld & gnt_valid & (gnt == i) & !reset. It is purely combinational and has no combinational path from in_ready back to in_valid.
- Transfer on input i: in_valid[i] & in_ready[i]. On that clk edge:
  - out_data <= channel i data.
  - out_ch <= i.
  - out_valid <= 1.
  - In MODE_RR only: ptr <= (i == N-1) ? 0 : i+1.
- Output drain: out_valid & out_ready with no new grant → out_valid <= 0. out_data and out_ch hold their last values.
- Simultaneous drain and load in the same cycle: the new word replaces the old one. There is no bubble.
- out_ready=0 while FULL:
  - out_data, out_valid and out_ch must stay stable.
  - All in_ready=0.
- Mode or s changes take effect on the next grant evaluation. They never alter a word already held. ptr is preserved across mode changes.
- Latency: input transfer at edge k → out_valid=1 after edge k. Sustained throughput is 1 word per cycle.
- Fairness: in MODE_RR with all N channels continuously valid and out_ready=1, grants cycle 0,1,…,N-1,0,… with no channel starved.

Decomposition:
- Package mux_pkg holds:
  - typedef enum logic {MODE_FIXED, MODE_RR} mux_mode_t.
  - A function to extract channel i from the packed in_data.
- Sub-module rr_pick (parameters N, SELW):
  - Combinational.
  - Inputs: req[N], ptr.
  - Outputs: gnt, gnt_valid.
  - Implements the wrap-around priority search.
- The top level holds the output register, ptr register, mode mux and ready generation.

Test Plan:
- Reset, then MODE_FIXED, s=2, in_valid=4'b0100, ch2=4'hA, out_ready=1:
  - in_ready=4'b0100.
  - Next cycle out_valid=1, out_data=4'hA, out_ch=2.
- MODE_FIXED, s=1, in_valid=4'b0100 → in_ready=0 and out_valid stays 0. With N=3, s=3, in_valid=3'b111 → no grant.
- MODE_RR, all four channels valid with data 1,2,3,4, out_ready=1 for 8 cycles → out_ch sequence 0,1,2,3,0,1,2,3 and out_data 1,2,3,4,1,2,3,4.
- Backpressure: out_ready=0 while FULL holding 4'h5 for 3 cycles → out_data=4'h5 stable and in_ready=0 throughout. Raise out_ready → next word loads the same cycle with no bubble.
- MODE_RR with ptr=3 after a ch2 grant, in_valid=4'b0011 → grant ch0, then ptr=1. With N=3 and ptr wrapping past 2 → ptr returns to 0.
- Assert reset while FULL and while in_valid=all ones → the same edge gives out_valid=0 and ptr=0. After release, the first RR grant is ch0.
